// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two ALU requesters, a consumer and the arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic [1:0] ReqValid;
  logic [1:0] ReqReady;
  logic [WIDTH-1:0] SrcA0;
  logic [WIDTH-1:0] SrcB0;
  logic [1:0] ALUControl0;
  logic [WIDTH-1:0] SrcA1;
  logic [WIDTH-1:0] SrcB1;
  logic [1:0] ALUControl1;
  logic RespValid;
  logic RespReady;
  logic [WIDTH-1:0] RespResult;
  logic RespId;
  logic [7:0] GrantCount0;
  logic [7:0] GrantCount1;
  modport master (
    output ReqValid, SrcA0, SrcB0, ALUControl0, SrcA1, SrcB1, ALUControl1, RespReady,
    input ReqReady, RespValid, RespResult, RespId, GrantCount0, GrantCount1
  );
  modport slave (
    input ReqValid, SrcA0, SrcB0, ALUControl0, SrcA1, SrcB1, ALUControl1, RespReady,
    output ReqReady, RespValid, RespResult, RespId, GrantCount0, GrantCount1
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one shared ALU with a one-entry result register
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic last_grant;
  logic resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic open;
  logic [1:0] grant;
  logic [1:0] req_ready;
  logic sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0] op;
  logic [WIDTH-1:0] alu;
  // Contention goes to the requester that did not win last; ready is also masked during reset
  always_comb begin
    open = (state == EMPTY) | bus.RespReady;
    grant = {bus.ReqValid[1] & (!bus.ReqValid[0] | !last_grant),
             bus.ReqValid[0] & (!bus.ReqValid[1] | last_grant)};
    req_ready = grant & {2{open & rst_n}};
    sel = grant[1];
  end
  // Shared ALU fed by the granted requester's operands
  always_comb begin
    op_a = sel ? bus.SrcA1 : bus.SrcA0;
    op_b = sel ? bus.SrcB1 : bus.SrcB0;
    op = sel ? bus.ALUControl1 : bus.ALUControl0;
    alu = op == 2'b00 ? op_a + op_b :
          op == 2'b01 ? op_a - op_b :
          op == 2'b10 ? op_a & op_b : op_a | op_b;
  end
  // Result register FSM: load on request transfer, drain on result transfer, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      resp_result <= '0;
      resp_id <= 1'b0;
      last_grant <= 1'b1;
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (|req_ready) begin
      state <= FULL;
      resp_result <= alu;
      resp_id <= sel;
      last_grant <= sel;
      if (req_ready[0] && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (req_ready[1] && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end else if (state == FULL && bus.RespReady) begin
      state <= EMPTY;
    end
  end
  assign bus.ReqReady = req_ready;
  assign bus.RespValid = state == FULL;
  assign bus.RespResult = resp_result;
  assign bus.RespId = resp_id;
  assign bus.GrantCount0 = cnt0;
  assign bus.GrantCount1 = cnt1;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_alu_arbiter;
  typedef struct {
    logic [31:0] res;
    logic id;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  item_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit m_last = 1'b1;
  int cnt[2] = '{0, 0};
  alu_arbiter_if #(.WIDTH(32)) bus();
  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] ref_alu(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction
  // Monitor: the oldest expected result must be presented; it leaves the queue when the consumer takes it
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("resp_valid", 64'(bus.RespValid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("resp_result", 64'(bus.RespResult), 64'(q[0].res));
        chk("resp_id", 64'(bus.RespId), 64'(q[0].id));
        if (bus.RespReady) void'(q.pop_front());
      end
    end
  end
  // Drive one cycle of stimulus, predict the grant and queue the expected result
  task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] c0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] c1, input logic rr);
    bit open;
    int g;
    logic [1:0] exp_rdy;
    item_t it;
    @(negedge clk);
    bus.ReqValid = v;
    bus.SrcA0 = a0;
    bus.SrcB0 = b0;
    bus.ALUControl0 = c0;
    bus.SrcA1 = a1;
    bus.SrcB1 = b1;
    bus.ALUControl1 = c1;
    bus.RespReady = rr;
    #2;
    open = q.size() == 0;
    g = (v == 2'b11) ? (m_last ? 0 : 1) : (v == 2'b10 ? 1 : 0);
    exp_rdy = (v == 2'b00 || !open) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
    chk("req_ready", 64'(bus.ReqReady), 64'(exp_rdy));
    chk("grant_count0", 64'(bus.GrantCount0), 64'(cnt[0]));
    chk("grant_count1", 64'(bus.GrantCount1), 64'(cnt[1]));
    if (exp_rdy != 2'b00) begin
      it.res = g == 1 ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
      it.id = g == 1;
      q.push_back(it);
      m_last = g == 1;
      if (cnt[g] < 255) cnt[g]++;
    end
  endtask
  task automatic rcyc(input logic [1:0] v, input logic rr);
    cyc(v, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), rr);
  endtask
  task automatic check_reset_state();
    chk("rst_resp_valid", 64'(bus.RespValid), 64'd0);
    chk("rst_resp_result", 64'(bus.RespResult), 64'd0);
    chk("rst_resp_id", 64'(bus.RespId), 64'd0);
    chk("rst_req_ready", 64'(bus.ReqReady), 64'd0);
    chk("rst_count0", 64'(bus.GrantCount0), 64'd0);
    chk("rst_count1", 64'(bus.GrantCount1), 64'd0);
  endtask
  // Pulse reset between clock edges with both requesters asking
  task automatic mid_reset();
    @(negedge clk);
    bus.ReqValid = 2'b11;
    bus.RespReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    q.delete();
    m_last = 1'b1;
    cnt = '{0, 0};
    bus.ReqValid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.ReqValid = 2'b11;
    bus.SrcA0 = '0;
    bus.SrcB0 = '0;
    bus.ALUControl0 = '0;
    bus.SrcA1 = '0;
    bus.SrcB1 = '0;
    bus.ALUControl1 = '0;
    bus.RespReady = 1'b1;
    #12;
    check_reset_state();
    @(negedge clk);
    bus.ReqValid = 2'b00;
    rst_n = 1'b1;
    cyc(2'b01, 32'd5, 32'd7, 2'd0, 32'd0, 32'd0, 2'd0, 1'b1);
    cyc(2'b10, 32'd0, 32'd0, 2'd0, 32'd0, 32'd1, 2'd1, 1'b1);
    cyc(2'b10, 32'd0, 32'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 1'b1);
    cyc(2'b00, 32'd0, 32'd0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b1);
    repeat (6) rcyc(2'b11, 1'b1);
    repeat (4) rcyc(2'b11, 1'b0);
    repeat (2) rcyc(2'b11, 1'b1);
    cyc(2'b01, 32'h0F0F_FFFF, 32'hFFFF_0000, 2'd2, 32'd0, 32'd0, 2'd0, 1'b1);
    rcyc(2'b11, 1'b0);
    mid_reset();
    repeat (3) rcyc(2'b11, 1'b1);
    mid_reset();
    repeat (300) rcyc(2'b01, 1'b1);
    rcyc(2'b00, 1'b1);
    chk("saturated_count0", 64'(bus.GrantCount0), 64'd255);
    chk("idle_count1", 64'(bus.GrantCount1), 64'd0);
    repeat (400) rcyc(2'($urandom), $urandom_range(0, 9) < 7);
    repeat (2) rcyc(2'b00, 1'b1);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have the following ports:
  - clk  input  1  sole clock; all state updates on rising edge.
  - rst_n  input  1  asynchronous, active-low reset.
  - ReqValid  input  2  per-requester request valid; bit i belongs to requester i.
  - ReqReady  output  2  per-requester accept; a request transfers when ReqValid[i] & ReqReady[i].
  - SrcA0, SrcB0  input  WIDTH each  requester 0 operands.
  - ALUControl0  input  2  requester 0 op: 00 ADD, 01 SUB, 10 AND, 11 OR.
  - SrcA1, SrcB1, ALUControl1  input  WIDTH, WIDTH, 2  requester 1 operands and op, same encoding.
  - RespValid  output  1  result register holds an unconsumed result.
  - RespReady  input  1  consumer accepts; a result transfers when RespValid & RespReady.
  - RespResult  output  WIDTH  registered ALU result.
  - RespId  output  1  index of the requester that issued the held result.
  - GrantCount0, GrantCount1  output  8 each  saturating count of accepted requests per requester.

Function
REQ-003 The block SHALL contain one shared ALU: ADD = SrcA+SrcB, SUB = SrcA-SrcB, AND, OR; WIDTH-bit, carry/borrow discarded (modulo 2^WIDTH).
REQ-004 The block SHALL have two states: EMPTY (RespValid=0) and FULL (RespValid=1).
REQ-005 The block SHALL define Open = !RespValid | RespReady, meaning the result register can load this cycle.
REQ-006 Grant SHALL be combinational, from ReqValid and a LastGrant register:
  - only one requester valid -> grant it;
  - both valid -> grant !LastGrant;
  - none valid -> no grant.
REQ-007 ReqReady[i] SHALL be Grant[i] & Open; at most one ReqReady bit SHALL be 1 per cycle.
REQ-008 ReqReady SHALL NOT depend on ReqValid of the same requester beyond REQ-006, and SHALL be 0 for a requester with ReqValid=0.
REQ-009 On a request transfer, the next edge SHALL:
  - load RespResult with the ALU output for the granted requester's operands;
  - load RespId with the granted index;
  - set RespValid=1 and LastGrant to the granted index.
REQ-010 Latency SHALL be exactly 1 cycle from request transfer to RespValid=1.
REQ-011 On a result transfer with no request transfer, the next edge SHALL clear RespValid; RespResult and RespId SHALL hold their values.
REQ-012 Simultaneous result transfer and request transfer SHALL reload the register (RespValid stays 1), sustaining one result per cycle.
REQ-013 While FULL and RespReady=0, RespResult, RespId and RespValid SHALL hold stable and ReqReady SHALL be 00.
REQ-014 LastGrant SHALL change only on a request transfer.
REQ-015 With both requesters continuously valid and RespReady=1, grants SHALL strictly alternate 0,1,0,1,...
REQ-016 GrantCountN SHALL increment by 1 on each transfer from requester N and SHALL saturate at 255 without wrapping.
REQ-017 Undefined ALUControl values (X/Z) are outside scope; all four encodings SHALL be decoded.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately, without waiting for clk, force:
  - RespValid=0, RespResult=0, RespId=0;
  - LastGrant=1, so requester 0 wins the first contention;
  - GrantCount0=GrantCount1=0.
REQ-019 A result pending when reset asserts SHALL be discarded; no transfer SHALL be reported for it.
REQ-020 While rst_n=0, ReqReady SHALL be 00.
REQ-021 The first request transfer SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-022 Single op: after reset, ReqValid=01, SrcA0=5, SrcB0=7, ALUControl0=00, RespReady=1 -> next cycle RespValid=1, RespResult=12, RespId=0, GrantCount0=1.
REQ-023 Wrap: requester 1 issues SUB with SrcA1=0, SrcB1=1 -> RespResult=32'hFFFFFFFF, RespId=1; ADD with 32'hFFFFFFFF+1 -> 0.
REQ-024 Contention: both valid every cycle, RespReady=1, for 6 cycles -> RespId sequence 0,1,0,1,0,1; ReqReady never 11.
REQ-025 Backpressure: RespValid=1, RespReady=0 for 4 cycles with both requests valid -> ReqReady=00; RespResult stable. Then RespReady=1 -> a new result loads on the next edge, back-to-back.
REQ-026 Reset mid-operation: RespValid=1 holding AND result 32'h0F0F0000; rst_n pulsed low between edges -> RespValid=0, RespResult=0 immediately, counters 0. With both requesters valid afterwards, requester 0 is granted first.
REQ-027 Saturation: 300 transfers from requester 0 -> GrantCount0=255, GrantCount1=0.
